// File: rtl/inst_mem_loader.sv
// Instruction-memory write loader: length header + little-endian words streamed in byte-wise,
// core held in reset until the image is complete. Optional trailing XOR checksum: CHECKSUM_EN.
module inst_mem_loader #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              cpu_rst,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CHK   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

`ifdef CHECKSUM_EN
  localparam state_t FINAL_ST = CHK;
`else
  localparam state_t FINAL_ST = DONE;
`endif

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              accept;
`ifdef CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      addr_q    <= BASE_ADDR;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
`ifdef CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  always_comb begin
    in_ready = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA) || (state_q == CHK);
    accept   = in_valid && in_ready;
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    word_d    = word_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef CHECKSUM_EN
    chk_d = accept ? (chk_q ^ in_data) : chk_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LEN0;
          addr_d  = BASE_ADDR;
          len_d   = '0;
          idx_d   = '0;
`ifdef CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
`ifdef CHECKSUM_EN
      ERR: begin
        if (start) begin
          state_d = LEN0;
          addr_d  = BASE_ADDR;
          len_d   = '0;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      CHK: begin
        if (accept) state_d = (in_data == chk_q) ? DONE : ERR;
      end
`endif
      LEN0: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d[15:8] = in_data;
          idx_d       = '0;
          state_d     = ({in_data, len_q[7:0]} == 16'd0) ? FINAL_ST : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          case (idx_q)
            2'd0:    word_d[7:0]   = in_data;
            2'd1:    word_d[15:8]  = in_data;
            2'd2:    word_d[23:16] = in_data;
            default: word_d[31:24] = in_data;
          endcase
          idx_d = idx_q + 2'd1;
          // Latch the write port only on a complete word so a partial word never reaches memory.
          if (idx_q == 2'd3) begin
            state_d   = WRITE;
            wr_addr_d = addr_q;
            wr_data_d = word_d;
          end
        end
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        len_d   = len_q - 16'd1;
        state_d = (len_q == 16'd1) ? FINAL_ST : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en   = (state_q == WRITE);
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign done    = (state_q == DONE);
  assign cpu_rst = (state_q != DONE);
`ifdef CHECKSUM_EN
  assign err     = (state_q == ERR);
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader; define CHECKSUM_EN to also exercise the checksum path.
module tb_inst_mem_loader;
  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, busy, done, cpu_rst, err;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          ready_viol = 0;
  logic [7:0]  tb_xor;

  inst_mem_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .cpu_rst(cpu_rst), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back({16'h0, wr_addr});
      wd.push_back(wr_data);
      if (in_ready) ready_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap = 0);
    int n = 0;
    in_valid = 1'b0;
    in_data  = 8'hEE;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    tb_xor   = tb_xor ^ b;
    in_valid = 1'b0;
    in_data  = 8'hEE;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    tb_xor = 8'h00;
  endtask

  task automatic finish_load();
`ifdef CHECKSUM_EN
    send_byte(tb_xor);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; tb_xor = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_wr_en",    {31'h0, wr_en},    32'h0);
    check("rst_wr_addr",  {16'h0, wr_addr},  32'h0);
    check("rst_wr_data",  wr_data,           32'h0);
    check("rst_busy",     {31'h0, busy},     32'h0);
    check("rst_done",     {31'h0, done},     32'h0);
    check("rst_err",      {31'h0, err},      32'h0);
    check("rst_cpu_rst",  {31'h0, cpu_rst},  32'h1);
    rst = 1'b0;
    @(negedge clk);

    // single word load
    do_start();
    check("t1_busy", {31'h0, busy}, 32'h1);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check("t1_wr_en", {31'h0, wr_en}, 32'h1);
    @(negedge clk);
    finish_load();
    check("t1_done",    {31'h0, done},    32'h1);
    check("t1_cpu_rst", {31'h0, cpu_rst}, 32'h0);
    check("t1_busy_end", {31'h0, busy},   32'h0);
    check("t1_nwr",  wa.size(), 32'd1);
    check("t1_addr", wa[0], 32'h0000);
    check("t1_data", wd[0], 32'h12345678);
    wa.delete(); wd.delete();

    // three words with in_valid gaps
    do_start();
    send_byte(8'h03, 2); send_byte(8'h00, 1);
    send_byte(8'hD4, 0); send_byte(8'hC3, 3); send_byte(8'hB2, 1); send_byte(8'hA1, 2);
    send_byte(8'hEF, 1); send_byte(8'hBE, 0); send_byte(8'hAD, 4); send_byte(8'hDE, 0);
    send_byte(8'h04, 3); send_byte(8'h03, 1); send_byte(8'h02, 0); send_byte(8'h01, 2);
    @(negedge clk);
    finish_load();
    check("t2_done", {31'h0, done}, 32'h1);
    check("t2_nwr", wa.size(), 32'd3);
    if (wa.size() == 3) begin
      check("t2_addr0", wa[0], 32'h0); check("t2_data0", wd[0], 32'hA1B2C3D4);
      check("t2_addr1", wa[1], 32'h1); check("t2_data1", wd[1], 32'hDEADBEEF);
      check("t2_addr2", wa[2], 32'h2); check("t2_data2", wd[2], 32'h01020304);
    end
    check("t2_ready_in_write", ready_viol, 32'd0);
    check("t2_hold_addr", {16'h0, wr_addr}, 32'h2);
    check("t2_hold_data", wr_data, 32'h01020304);
    wa.delete(); wd.delete();

    // reload from DONE restarts at base address
    do_start();
    check("t6_cpu_rst", {31'h0, cpu_rst}, 32'h1);
    check("t6_done",    {31'h0, done},    32'h0);
    check("t6_busy",    {31'h0, busy},    32'h1);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
    @(negedge clk);
    finish_load();
    check("t6_done_end", {31'h0, done}, 32'h1);
    check("t6_nwr",  wa.size(), 32'd1);
    check("t6_addr", wa[0], 32'h0);
    check("t6_data", wd[0], 32'hCAFEF00D);
    wa.delete(); wd.delete();

    // zero-length image
    do_start();
    send_byte(8'h00); send_byte(8'h00);
    finish_load();
    check("t3_done",    {31'h0, done},    32'h1);
    check("t3_cpu_rst", {31'h0, cpu_rst}, 32'h0);
    check("t3_nwr",     wa.size(),        32'd0);

    // reset in the middle of the second word
    do_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_busy",     {31'h0, busy},     32'h0);
    check("t4_cpu_rst",  {31'h0, cpu_rst},  32'h1);
    check("t4_done",     {31'h0, done},     32'h0);
    check("t4_in_ready", {31'h0, in_ready}, 32'h0);
    check("t4_wr_addr",  {16'h0, wr_addr},  32'h0);
    in_valid = 1'b1; in_data = 8'h77;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    check("t4_nwr",  wa.size(), 32'd1);
    check("t4_data", wd[0], 32'h44332211);
    wa.delete(); wd.delete();

`ifdef CHECKSUM_EN
    do_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    @(negedge clk);
    send_byte(8'h00);
    check("t5_err",      {31'h0, err},      32'h1);
    check("t5_done_bad", {31'h0, done},     32'h0);
    check("t5_cpu_rst",  {31'h0, cpu_rst},  32'h1);
    check("t5_in_ready", {31'h0, in_ready}, 32'h0);
    do_start();
    check("t5_err_clr", {31'h0, err}, 32'h0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    @(negedge clk);
    send_byte(8'h09);
    check("t5_done_good", {31'h0, done}, 32'h1);
    check("t5_err_good",  {31'h0, err},  32'h0);
    check("t5_nwr", wa.size(), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
